// File: rtl/cp_s1_write_ram_if.sv
// Sample stream input and RAM port-A write bus of the stage-1 RAM writer.
// master: stream source / RAM side; slave: the writer.
interface cp_s1_write_ram_if #(
    parameter int SAMPLE_WIDTH    = 32,
    parameter int WRITE_RAM_WIDTH = 128
);
    logic [SAMPLE_WIDTH-1:0]    i_data;
    logic                       i_data_valid;
    logic                       i_data_last;
    logic                       o_ready;
    logic [WRITE_RAM_WIDTH-1:0] o_m1_wr_data;
    logic [31:0]                o_m1_wr_addr;
    logic                       o_m1_wr_en;
    logic                       o_m1_wr_wea;

    modport master (
        output i_data, i_data_valid, i_data_last,
        input  o_ready, o_m1_wr_data, o_m1_wr_addr,
        input  o_m1_wr_en, o_m1_wr_wea
    );

    modport slave (
        input  i_data, i_data_valid, i_data_last,
        output o_ready, o_m1_wr_data, o_m1_wr_addr,
        output o_m1_wr_en, o_m1_wr_wea
    );
endinterface

// File: rtl/cp_s1_write_ram.sv
// Packs a valid/ready sample stream into RAM words and writes them
// along a wrapping address sequence, one frame per start.
module cp_s1_write_ram #(
    parameter int WRITE_RAM_WIDTH = 128,
    parameter int SAMPLE_WIDTH    = 32,
    parameter int DATA_NUM        = 1024,
    parameter int INIT_ADDR       = 0,
    parameter int ADD_ADDR        = 1,
    parameter int END_ADDR        = 1024
) (
    input  logic             clk_200m,
    input  logic             rst_n,
    input  logic             i_start,
    cp_s1_write_ram_if.slave s,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_short
);
    localparam int LANES = WRITE_RAM_WIDTH / SAMPLE_WIDTH;
    localparam int LCW   = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int WCW   = $clog2(DATA_NUM) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FILL = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]                 state;
    logic [1:0]                 state_nxt;
    logic [LCW-1:0]             lane_cnt;
    logic [WCW-1:0]             word_cnt;
    logic [31:0]                addr;
    logic [31:0]                addr_nxt;
    logic [32:0]                addr_sum;
    logic [WRITE_RAM_WIDTH-1:0] pack;
    logic [WRITE_RAM_WIDTH-1:0] word;
    logic                       accept;
    logic                       close;
    logic                       last_word;
    logic                       finish;

    assign accept    = (state == FILL) && s.i_data_valid && s.o_ready;
    assign last_word = (word_cnt == WCW'(DATA_NUM - 1));
    assign close     = accept &&
                       (s.i_data_last || lane_cnt == LCW'(LANES - 1));
    assign finish    = close && (last_word || s.i_data_last);

    // pack only ever holds lanes below lane_cnt, so upper lanes stay zero
    always_comb begin
        word = pack;
        for (int k = 0; k < LANES; k++) begin
            if (lane_cnt == LCW'(k)) begin
                word[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = s.i_data;
            end
        end
    end

    always_comb begin
        addr_sum = {1'b0, addr} + 33'(ADD_ADDR);
        addr_nxt = (addr_sum >= 33'(END_ADDR)) ?
                   32'(INIT_ADDR) : addr_sum[31:0];
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (i_start) state_nxt = FILL;
            FILL:    if (finish) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_200m or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            lane_cnt       <= '0;
            word_cnt       <= '0;
            addr           <= 32'(INIT_ADDR);
            pack           <= '0;
            s.o_ready      <= 1'b0;
            s.o_m1_wr_en   <= 1'b0;
            s.o_m1_wr_wea  <= 1'b0;
            s.o_m1_wr_addr <= '0;
            s.o_m1_wr_data <= '0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_short        <= 1'b0;
        end else begin
            state         <= state_nxt;
            s.o_ready     <= (state_nxt == FILL);
            o_busy        <= (state_nxt != IDLE);
            s.o_m1_wr_en  <= close;
            s.o_m1_wr_wea <= close;
            o_done        <= finish;
            o_short       <= finish && !last_word;
            if (state == IDLE && i_start) begin
                lane_cnt <= '0;
                word_cnt <= '0;
                addr     <= 32'(INIT_ADDR);
                pack     <= '0;
            end else if (close) begin
                lane_cnt       <= '0;
                pack           <= '0;
                word_cnt       <= word_cnt + 1'b1;
                addr           <= addr_nxt;
                s.o_m1_wr_data <= word;
                s.o_m1_wr_addr <= addr;
            end else if (accept) begin
                lane_cnt <= lane_cnt + 1'b1;
                pack     <= word;
            end
        end
    end
endmodule

// File: tb/tb_cp_s1_write_ram.sv
// Randomized bench for cp_s1_write_ram: default-size instance checked
// against a transaction-level model, plus a small wrapping instance.
`timescale 1ns/1ps
module tb_cp_s1_write_ram;
    localparam int SW     = 32;
    localparam int RW     = 128;
    localparam int LN     = 4;
    localparam int A_DN   = 1024;
    localparam int A_INIT = 0;
    localparam int A_ADD  = 1;
    localparam int A_END  = 1024;

    logic clk_200m = 1'b0;
    logic rst_n    = 1'b0;
    always #5 clk_200m = ~clk_200m;

    cp_s1_write_ram_if #(.SAMPLE_WIDTH(SW), .WRITE_RAM_WIDTH(RW)) ifa ();
    cp_s1_write_ram_if #(.SAMPLE_WIDTH(SW), .WRITE_RAM_WIDTH(RW)) ifb ();

    logic a_start = 1'b0, a_busy, a_done, a_short;
    logic b_start = 1'b0, b_busy, b_done, b_short;

    cp_s1_write_ram u_dut (
        .clk_200m(clk_200m), .rst_n(rst_n), .i_start(a_start),
        .s(ifa), .o_busy(a_busy), .o_done(a_done), .o_short(a_short)
    );

    cp_s1_write_ram #(
        .DATA_NUM(5), .INIT_ADDR(1000), .ADD_ADDR(8), .END_ADDR(1024)
    ) u_wrap (
        .clk_200m(clk_200m), .rst_n(rst_n), .i_start(b_start),
        .s(ifb), .o_busy(b_busy), .o_done(b_done), .o_short(b_short)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_chk++;
        $display("FAIL %s: got timeout want event", name);
    endtask

    // Transaction-level model: accepted samples -> expected writes
    typedef struct {
        logic [127:0] data;
        logic [31:0]  addr;
        logic         done;
        logic         shrt;
        int           cyc;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] m_lane[LN];
    int          m_nl   = 0;
    int          m_word = 0;
    logic [31:0] m_addr = A_INIT;
    bit          m_infr = 0;
    int          cyc    = 0;

    always @(posedge clk_200m) cyc <= cyc + 1;

    task automatic model_accept(input logic [31:0] d, input logic last);
        wr_t          w;
        logic [127:0] wd;
        longint       nx;
        m_lane[m_nl] = d;
        m_nl++;
        m_infr = 1;
        if (last || m_nl == LN) begin
            wd = '0;
            for (int k = 0; k < m_nl; k++) wd[k*SW +: SW] = m_lane[k];
            m_word++;
            w.data = wd;
            w.addr = m_addr;
            w.done = last || (m_word == A_DN);
            w.shrt = w.done && (m_word < A_DN);
            w.cyc  = cyc;
            exp_q.push_back(w);
            m_nl = 0;
            nx = longint'(m_addr) + A_ADD;
            m_addr = (nx >= A_END) ? A_INIT : 32'(nx);
            if (w.done) begin
                m_word = 0;
                m_addr = A_INIT;
                m_infr = 0;
            end
        end
    endtask

    always @(posedge clk_200m)
        if (rst_n && ifa.i_data_valid && ifa.o_ready)
            model_accept(ifa.i_data, ifa.i_data_last);

    always @(negedge rst_n) begin
        m_nl = 0;
        m_word = 0;
        m_addr = A_INIT;
        m_infr = 0;
        exp_q.delete();
    end

    logic [127:0] ram_a[A_DN];
    int a_wr_cnt = 0, a_done_cnt = 0, a_sd_cnt = 0;
    int gap_run = 0, last_gap = -1;
    bit no_cons = 0, prev_en = 0;

    always @(negedge clk_200m) begin : mon_a
        bit  e;
        wr_t w;
        if (rst_n) begin
            e = exp_q.size() > 0 && exp_q[0].cyc + 1 == cyc;
            chk("a_wr_en", ifa.o_m1_wr_en, e);
            chk("a_wr_wea", ifa.o_m1_wr_wea, e);
            if (e) begin
                w = exp_q.pop_front();
                chk("a_wr_data", ifa.o_m1_wr_data, w.data);
                chk("a_wr_addr", ifa.o_m1_wr_addr, w.addr);
                chk("a_done", a_done, w.done);
                chk("a_short", a_short, w.shrt);
                chk("a_busy_wr", a_busy, 1);
                if (w.done) chk("a_ready_done", ifa.o_ready, 0);
            end else begin
                chk("a_done_idle", a_done, 0);
                chk("a_short_idle", a_short, 0);
            end
            if (m_infr) chk("a_ready_fill", ifa.o_ready, 1);
            if (no_cons && prev_en) chk("a_nocons", ifa.o_m1_wr_en, 0);
            prev_en = ifa.o_m1_wr_en;
            if (ifa.o_m1_wr_en) begin
                ram_a[ifa.o_m1_wr_addr[9:0]] = ifa.o_m1_wr_data;
                a_wr_cnt++;
                if (a_done) a_done_cnt++;
                if (a_done && a_short) a_sd_cnt++;
            end
            if (!ifa.o_ready) gap_run++;
            else begin
                if (gap_run > 0) last_gap = gap_run;
                gap_run = 0;
            end
        end
    end

    logic [31:0]  b_addr_q[$];
    logic [127:0] b_data_q[$];
    int b_done_at = -1, b_short_n = 0;

    always @(negedge clk_200m)
        if (rst_n && ifb.o_m1_wr_en) begin
            b_addr_q.push_back(ifb.o_m1_wr_addr);
            b_data_q.push_back(ifb.o_m1_wr_data);
            if (b_done) b_done_at = b_addr_q.size();
            if (b_short) b_short_n++;
        end

    bit abort = 0;

    task automatic send(input bit b, input logic [31:0] d,
                        input logic last, input int p);
        int n;
        if (abort) return;
        while ($urandom_range(99) < p) @(negedge clk_200m);
        if (b) begin
            ifb.i_data = d; ifb.i_data_last = last; ifb.i_data_valid = 1;
        end else begin
            ifa.i_data = d; ifa.i_data_last = last; ifa.i_data_valid = 1;
        end
        n = 0;
        while (!(b ? ifb.o_ready : ifa.o_ready)) begin
            @(negedge clk_200m);
            n++;
            if (n > 200) begin
                fail("send_timeout");
                abort = 1;
                break;
            end
        end
        @(negedge clk_200m);
        if (b) ifb.i_data_valid = 0;
        else ifa.i_data_valid = 0;
    endtask

    task automatic wait_done(input bit b);
        int n = 0;
        while (!(b ? b_done : a_done) && n < 50) begin
            @(negedge clk_200m);
            n++;
        end
        if (n >= 50) fail("wait_done");
        repeat (3) @(negedge clk_200m);
    endtask

    task automatic clr_a();
        a_wr_cnt = 0; a_done_cnt = 0; a_sd_cnt = 0;
        for (int i = 0; i < A_DN; i++) ram_a[i] = '0;
    endtask

    function automatic logic [127:0] ramp_word(input int n);
        return {32'(4*n+3), 32'(4*n+2), 32'(4*n+1), 32'(4*n)};
    endfunction

    task automatic check_ramp_frame(input string name);
        int bad = 0;
        for (int i = 0; i < A_DN; i++)
            if (ram_a[i] !== ramp_word(i)) bad++;
        chk(name, bad, 0);
    endtask

    initial begin
        int t0, t1, t2;
        logic [31:0] b_exp_addr[5];
        b_exp_addr = '{32'd1000, 32'd1008, 32'd1016, 32'd1000, 32'd1008};
        ifa.i_data = '0; ifa.i_data_valid = 0; ifa.i_data_last = 0;
        ifb.i_data = '0; ifb.i_data_valid = 0; ifb.i_data_last = 0;

        repeat (3) @(negedge clk_200m);
        chk("rst_ready", ifa.o_ready, 0);
        chk("rst_wr_en", ifa.o_m1_wr_en, 0);
        chk("rst_wr_addr", ifa.o_m1_wr_addr, 0);
        chk("rst_wr_data", ifa.o_m1_wr_data, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        rst_n = 1;
        @(negedge clk_200m);

        // full frame at full rate
        clr_a();
        a_start = 1;
        send(0, 0, 0, 0);
        t0 = cyc;
        a_start = 0;
        for (int i = 1; i < 4*A_DN; i++) send(0, i, 0, 0);
        t1 = cyc;
        wait_done(0);
        chk("full_rate", t1 - t0, 4*A_DN - 1);
        chk("full_wr_cnt", a_wr_cnt, A_DN);
        chk("full_done_cnt", a_done_cnt, 1);
        chk("full_short_cnt", a_sd_cnt, 0);
        chk("full_word0", ram_a[0], 128'h00000003_00000002_00000001_00000000);
        chk("full_word1023", ram_a[1023],
            128'h00000fff_00000ffe_00000ffd_00000ffc);
        check_ramp_frame("full_ram_bad");

        // random valid gaps
        clr_a();
        no_cons = 1;
        a_start = 1;
        send(0, 0, 0, 50);
        a_start = 0;
        for (int i = 1; i < 4*A_DN; i++) send(0, i, 0, 50);
        wait_done(0);
        no_cons = 0;
        chk("rand_wr_cnt", a_wr_cnt, A_DN);
        chk("rand_word5", ram_a[5], 128'h00000017_00000016_00000015_00000014);
        check_ramp_frame("rand_ram_bad");

        // early last on sample 6
        clr_a();
        a_start = 1;
        send(0, 0, 0, 0);
        a_start = 0;
        for (int i = 1; i < 7; i++) send(0, i, i == 6, 0);
        wait_done(0);
        chk("early_wr_cnt", a_wr_cnt, 2);
        chk("early_word1", ram_a[1], 128'h00000000_00000006_00000005_00000004);
        chk("early_done_short", a_sd_cnt, 1);

        // wrapping address sequence on the small instance
        b_start = 1;
        send(1, 0, 0, 0);
        b_start = 0;
        for (int i = 1; i < 20; i++) send(1, i, 0, 0);
        wait_done(1);
        chk("wrap_wr_cnt", b_addr_q.size(), 5);
        for (int n = 0; n < 5; n++)
            if (n < b_addr_q.size()) begin
                chk("wrap_addr", b_addr_q[n], b_exp_addr[n]);
                chk("wrap_data", b_data_q[n], ramp_word(n));
            end
        chk("wrap_done_at", b_done_at, 5);
        chk("wrap_short", b_short_n, 0);
        ifb.i_data = 32'd999;
        ifb.i_data_valid = 1;
        repeat (5) begin
            @(negedge clk_200m);
            chk("wrap_stall_ready", ifb.o_ready, 0);
        end
        ifb.i_data_valid = 0;
        chk("wrap_stall_wr_cnt", b_addr_q.size(), 5);

        // back-to-back frames with start held high
        clr_a();
        a_start = 1;
        for (int i = 0; i < 10; i++) send(0, i, i == 9, 0);
        t1 = cyc;
        send(0, 100, 0, 0);
        t2 = cyc;
        a_start = 0;
        for (int i = 101; i < 106; i++) send(0, i, i == 105, 0);
        wait_done(0);
        chk("b2b_accept_gap", t2 - t1, 3);
        chk("b2b_ready_gap", last_gap, 2);
        chk("b2b_wr_cnt", a_wr_cnt, 5);
        chk("b2b_done_cnt", a_done_cnt, 2);
        chk("b2b_word0", ram_a[0], 128'h00000067_00000066_00000065_00000064);
        chk("b2b_word1", ram_a[1], 128'h00000000_00000000_00000069_00000068);

        // reset after two samples of word 3
        clr_a();
        a_start = 1;
        send(0, 0, 0, 0);
        a_start = 0;
        for (int i = 1; i < 14; i++) send(0, i, 0, 0);
        rst_n = 0;
        #1;
        chk("mrst_ready", ifa.o_ready, 0);
        chk("mrst_wr_en", ifa.o_m1_wr_en, 0);
        chk("mrst_wr_wea", ifa.o_m1_wr_wea, 0);
        chk("mrst_wr_addr", ifa.o_m1_wr_addr, 0);
        chk("mrst_wr_data", ifa.o_m1_wr_data, 0);
        chk("mrst_busy", a_busy, 0);
        repeat (3) @(negedge clk_200m);
        rst_n = 1;
        repeat (3) @(negedge clk_200m);
        chk("mrst_idle_ready", ifa.o_ready, 0);
        chk("mrst_wr_cnt", a_wr_cnt, 3);
        a_start = 1;
        send(0, 200, 0, 0);
        a_start = 0;
        for (int i = 201; i < 208; i++) send(0, i, i == 207, 0);
        wait_done(0);
        chk("mrst_new_wr_cnt", a_wr_cnt, 5);
        chk("mrst_word0", ram_a[0], 128'h000000cb_000000ca_000000c9_000000c8);
        chk("mrst_word3_kept", ram_a[3], 128'h0);
        chk("mrst_exp_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/cp_s1_write_ram.md
# cp_s1_write_ram

Stream-to-RAM writer for the chirp preprocessing stage-1 datapath. It accepts a valid/ready sample stream and packs SAMPLE_WIDTH samples into WRITE_RAM_WIDTH words. It writes each word to a simple-dual-port RAM port A through the m1 write interface (en/wea/addr/data), walking a programmable address sequence. It is the write-side counterpart of cp_s1_read_ram: a frame written here reads back unchanged through that block when both use the same address parameters.

## Interface
- WRITE_RAM_WIDTH, 128, RAM word width; must be an integer multiple of SAMPLE_WIDTH
- SAMPLE_WIDTH, 32, input sample width; LANES = WRITE_RAM_WIDTH/SAMPLE_WIDTH (4 at defaults)
- DATA_NUM, 1024, RAM words per frame
- INIT_ADDR, 0, first write address of each frame
- ADD_ADDR, 1, address increment per word
- END_ADDR, 1024, exclusive address bound; wrap point

- clk_200m  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- i_start  in  1  level; sampled in IDLE to arm a frame
- i_data  in  SAMPLE_WIDTH  input sample
- i_data_valid  in  1  sample valid
- i_data_last  in  1  final sample of frame; qualified by valid&ready
- o_ready  out  1  sample accept; high only in FILL
- o_m1_wr_data  out  WRITE_RAM_WIDTH  packed word
- o_m1_wr_addr  out  32  write address
- o_m1_wr_en  out  1  write strobe, one cycle per word
- o_m1_wr_wea  out  1  byte-all write enable; equals o_m1_wr_en
- o_busy  out  1  high in FILL and DONE
- o_done  out  1  one-cycle frame-complete pulse
- o_short  out  1  one-cycle pulse with o_done when the frame ended early on i_data_last

## Operation
- Reset: all outputs 0, state IDLE, lane counter 0, word counter 0, address register INIT_ADDR, pack register 0.
- States:
  - IDLE: if i_start=1, go to FILL; lane counter, word counter and address are reloaded (address = INIT_ADDR).
  - FILL: accept samples on i_data_valid & o_ready. Sample k of a word goes to bits [(k+1)*SAMPLE_WIDTH-1 : k*SAMPLE_WIDTH], so lane 0 occupies the LSBs.
  - On acceptance of lane LANES-1, or of any lane with i_data_last=1, the word is written on the next cycle.
  - Unfilled upper lanes of a word closed by last are written as zero.
  - DONE: one cycle, then IDLE.
- FILL → DONE when the word being closed is word DATA_NUM-1, or when i_data_last closes the word. o_short=1 if the word count is below DATA_NUM at that point.
- i_data_last on the final lane of word DATA_NUM-1 is a normal end, with o_short=0.
- Samples after DATA_NUM words without last are stalled, because o_ready=0; they belong to the next frame.
- Address sequence: next = addr + ADD_ADDR; if next ≥ END_ADDR, next = INIT_ADDR (wrap). Computed in 33 bits so there is no overflow.
- Word counter width is clog2(DATA_NUM)+1; lane counter width is clog2(LANES), minimum 1.
- With i_start tied high, frames run back to back; IDLE lasts one cycle.
- Reset mid-frame: a partially packed word is discarded and no write is issued. Nothing resumes until IDLE re-arms.

## Timing
- o_ready is registered from state; it is high in every FILL cycle (there is no internal backpressure).
- Write latency: the word is accepted on edge t, and o_m1_wr_en, wea, addr and data are valid for the single cycle after t.
- o_m1_wr_addr and o_m1_wr_data hold their last values while o_m1_wr_en=0.
- Full-rate input gives one write every LANES cycles.
- Final word: the cycle with o_m1_wr_en=1 is the DONE cycle, and o_done (and o_short, if applicable) is high in that same cycle. It is followed by IDLE, then FILL.
- Frame-to-frame ready gap is 2 cycles (DONE, IDLE) after the final acceptance cycle.

## Test plan
- Full frame at defaults, samples 0..4095 back to back:
  - 1024 writes, addr 0..1023.
  - Word n = {4n+3, 4n+2, 4n+1, 4n}.
  - o_done pulse with the last write; o_short=0.
- Valid toggled randomly (50%): identical RAM contents and addresses to the full-frame case; wr_en never high in two consecutive cycles.
- Early last on sample 6 (word 1, lane 2):
  - word 1 = {0, 6, 5, 4} written at addr 1.
  - o_done=1 and o_short=1 in the same cycle.
- Wrap: INIT_ADDR=1000, ADD_ADDR=8, END_ADDR=1024, DATA_NUM=5 → addresses 1000, 1008, 1016, 1000, 1008.
- i_start held high, two frames back to back: the second frame restarts at INIT_ADDR; o_ready is low for exactly 2 cycles between frames.
- rst_n pulsed low after 2 samples of word 3:
  - all outputs go to 0 immediately, with no write of the partial word.
  - The next frame starts at INIT_ADDR with word 0.
